// File: rtl/prescaled_counter.sv
// prescaled_counter: programmable-ratio prescaler that produces a one-cycle
// tick enable, driving a WIDTH-bit up/down counter with synchronous load and
// carry/borrow reporting. Everything runs in the clkin domain.
// Optional feature macro: PRESCALED_COUNTER_SATURATE_EN. When it is defined,
// the counter saturates at its limits instead of wrapping. tc then flags
// each step that was blocked by saturation.
module prescaled_counter #(
    parameter int WIDTH    = 8,
    parameter int DIV_W    = 7,
    parameter int DIV_FAST = 100,
    parameter int DIV_SLOW = 25
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             en,
    input  logic             fast,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tick,
    output logic             tc,
    output logic [WIDTH-1:0] counter,
    output logic [DIV_W-1:0] presc
);

    // Terminal prescaler values (D-1). They fit in DIV_W bits because D <= 2^DIV_W.
    localparam logic [DIV_W-1:0] TERM_FAST  = DIV_W'(DIV_FAST - 1);
    localparam logic [DIV_W-1:0] TERM_SLOW  = DIV_W'(DIV_SLOW - 1);
    localparam logic [DIV_W-1:0] PRESC_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] PRESC_ONE  = DIV_W'(1);
    localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

    // Reject out-of-range divide ratios at elaboration.
    generate
        if ((DIV_FAST < 2) || (DIV_FAST > (1 << DIV_W))) begin : g_bad_div_fast
            $error("prescaled_counter: DIV_FAST must lie in 2..2^DIV_W");
        end
        if ((DIV_SLOW < 2) || (DIV_SLOW > (1 << DIV_W))) begin : g_bad_div_slow
            $error("prescaled_counter: DIV_SLOW must lie in 2..2^DIV_W");
        end
    endgenerate

    logic [DIV_W-1:0] presc_q,   presc_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic             tick_q,    tick_d;
    logic             tc_q,      tc_d;
    logic [DIV_W-1:0] term_s;
    logic             terminal_s;

    // Select the active terminal value. The >= test lets the prescaler recover when
    // the ratio shrinks while presc is already past the new terminal.
    always_comb begin
        term_s     = fast ? TERM_FAST : TERM_SLOW;
        terminal_s = (presc_q >= term_s);
    end

    // Next-state logic. Priority is load > freeze > normal counting.
    // Reset is applied in the register block.
    always_comb begin
        presc_d   = presc_q;
        counter_d = counter_q;
        tick_d    = 1'b0;
        tc_d      = 1'b0;
        if (load) begin
            counter_d = load_val;
            presc_d   = PRESC_ZERO;
        end else if (!en) begin
            presc_d   = presc_q;
            counter_d = counter_q;
        end else if (terminal_s) begin
            presc_d = PRESC_ZERO;
            tick_d  = 1'b1;
            if (up_dn) begin
                if (counter_q == CNT_MAX) begin
`ifdef PRESCALED_COUNTER_SATURATE_EN
                    counter_d = CNT_MAX;
`else
                    counter_d = CNT_MIN;
`endif
                    tc_d = 1'b1;
                end else begin
                    counter_d = counter_q + CNT_ONE;
                end
            end else begin
                if (counter_q == CNT_MIN) begin
`ifdef PRESCALED_COUNTER_SATURATE_EN
                    counter_d = CNT_MIN;
`else
                    counter_d = CNT_MAX;
`endif
                    tc_d = 1'b1;
                end else begin
                    counter_d = counter_q - CNT_ONE;
                end
            end
        end else begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clkin) begin
        if (!reset) begin
            presc_q   <= PRESC_ZERO;
            counter_q <= CNT_MIN;
            tick_q    <= 1'b0;
            tc_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            counter_q <= counter_d;
            tick_q    <= tick_d;
            tc_q      <= tc_d;
        end
    end

    assign tick    = tick_q;
    assign tc      = tc_q;
    assign counter = counter_q;
    assign presc   = presc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Self-checking bench for prescaled_counter. An integer-arithmetic reference
// model is checked against the DUT on every cycle. Directed literal
// expectations pin the model at the interesting points.
// Honours PRESCALED_COUNTER_SATURATE_EN in the same way as the design.
module tb_prescaled_counter;

    localparam int WIDTH = 8;
    localparam int DIV_W = 7;
    localparam int DF    = 100;
    localparam int DS    = 25;
    localparam int MODV  = 1 << WIDTH;

`ifdef PRESCALED_COUNTER_SATURATE_EN
    localparam int WRAP_CNT   = 8'hFF;
    localparam int BORROW_CNT = 8'h00;
`else
    localparam int WRAP_CNT   = 8'h00;
    localparam int BORROW_CNT = 8'hFF;
`endif

    logic             clkin = 1'b0;
    logic             reset;
    logic             en;
    logic             fast;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             tick;
    logic             tc;
    logic [WIDTH-1:0] counter;
    logic [DIV_W-1:0] presc;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model state, kept as plain integers.
    int m_presc = 0;
    int m_cnt   = 0;
    int m_tick  = 0;
    int m_tc    = 0;

    prescaled_counter #(
        .WIDTH(WIDTH), .DIV_W(DIV_W), .DIV_FAST(DF), .DIV_SLOW(DS)
    ) dut (
        .clkin(clkin), .reset(reset), .en(en), .fast(fast), .up_dn(up_dn),
        .load(load), .load_val(load_val), .tick(tick), .tc(tc),
        .counter(counter), .presc(presc)
    );

    always #5 clkin = ~clkin;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: derive the next outputs from the behaviour rules.
    always @(posedge clkin) begin
        int d;
        int nxt;
        d = fast ? DF : DS;
        if (reset !== 1'b1) begin
            m_presc = 0; m_cnt = 0; m_tick = 0; m_tc = 0;
        end else if (load) begin
            m_cnt = int'(load_val); m_presc = 0; m_tick = 0; m_tc = 0;
        end else if (!en) begin
            m_tick = 0; m_tc = 0;
        end else if (m_presc >= d - 1) begin
            m_presc = 0;
            m_tick  = 1;
            nxt     = up_dn ? m_cnt + 1 : m_cnt - 1;
            m_tc    = (nxt < 0 || nxt >= MODV) ? 1 : 0;
`ifdef PRESCALED_COUNTER_SATURATE_EN
            if (m_tc == 0) m_cnt = nxt;
`else
            m_cnt = (nxt + MODV) % MODV;
`endif
        end else begin
            m_presc = m_presc + 1;
            m_tick  = 0;
            m_tc    = 0;
        end
    end

    // Per-cycle compare of DUT against the model, sampled after the edge.
    always @(posedge clkin) begin
        #1;
        if (chk_en) begin
            check("model_tick",    32'(tick),    32'(m_tick));
            check("model_tc",      32'(tc),      32'(m_tc));
            check("model_counter", 32'(counter), 32'(m_cnt));
            check("model_presc",   32'(presc),   32'(m_presc));
        end
    end

    // Wait for the next tick, returning the number of edges taken (bounded).
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(posedge clkin);
            #1;
            n++;
        end while (tick !== 1'b1 && n < 400);
        if (tick !== 1'b1) check("tick_timeout", 32'(tick), 32'd1);
    endtask

    task automatic do_reset(input logic f);
        @(negedge clkin);
        reset = 1'b0; load = 1'b0;
        @(negedge clkin);
        reset = 1'b1; en = 1'b1; fast = f; up_dn = 1'b1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v, input logic dir);
        @(negedge clkin);
        load = 1'b1; load_val = v; up_dn = dir; fast = 1'b0;
        @(negedge clkin);
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; en = 1'b0; fast = 1'b0; up_dn = 1'b1;
        load = 1'b0; load_val = 8'h00;

        // Reset for three cycles, then default slow rate counting up.
        repeat (3) @(negedge clkin);
        chk_en = 1'b1;
        check("rst_counter", 32'(counter), 32'd0);
        check("rst_tick",    32'(tick),    32'd0);
        check("rst_presc",   32'(presc),   32'd0);
        reset = 1'b1; en = 1'b1; fast = 1'b0; up_dn = 1'b1;
        wait_tick(n);
        check("slow_first_latency", 32'(n), 32'd25);
        check("slow_first_count",   32'(counter), 32'd1);
        wait_tick(n);
        check("slow_period",        32'(n), 32'd25);
        check("slow_second_count",  32'(counter), 32'd2);

        // Fast rate: three ticks in 300 cycles.
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            wait_tick(n);
            check("fast_period", 32'(n), 32'd100);
        end
        check("fast_count_300", 32'(counter), 32'd3);
        check("fast_tc",        32'(tc), 32'd0);

        // Up wrap from FE.
        do_load(8'hFE, 1'b1);
        check("load_fe", 32'(counter), 32'hFE);
        wait_tick(n);
        check("wrap_latency", 32'(n), 32'd25);
        check("wrap_ff",      32'(counter), 32'hFF);
        check("wrap_ff_tc",   32'(tc), 32'd0);
        wait_tick(n);
        check("wrap_00",      32'(counter), 32'(WRAP_CNT));
        check("wrap_tc",      32'(tc), 32'd1);
        @(posedge clkin); #1;
        check("wrap_tc_one_cycle", 32'(tc), 32'd0);

        // Down borrow from 01.
        do_load(8'h01, 1'b0);
        wait_tick(n);
        check("borrow_00",    32'(counter), 32'h00);
        check("borrow_00_tc", 32'(tc), 32'd0);
        wait_tick(n);
        check("borrow_ff",    32'(counter), 32'(BORROW_CNT));
        check("borrow_tc",    32'(tc), 32'd1);

        // Mode switch at presc=50: slow ratio wraps on the next edge.
        do_reset(1'b1);
        repeat (50) @(posedge clkin);
        @(negedge clkin);
        check("switch_presc50", 32'(presc), 32'd50);
        fast = 1'b0;
        @(posedge clkin); #1;
        check("switch_tick",  32'(tick), 32'd1);
        check("switch_presc", 32'(presc), 32'd0);
        wait_tick(n);
        check("switch_period", 32'(n), 32'd25);
        check("switch_count",  32'(counter), 32'd2);

        // Load on a terminal edge: load wins, no tick.
        repeat (24) @(posedge clkin);
        @(negedge clkin);
        check("term_presc", 32'(presc), 32'd24);
        load = 1'b1; load_val = 8'h5A;
        @(posedge clkin); #1;
        check("term_load_tick",    32'(tick), 32'd0);
        check("term_load_counter", 32'(counter), 32'h5A);
        check("term_load_presc",   32'(presc), 32'd0);
        @(negedge clkin);
        load = 1'b0;

        // Freeze for 40 cycles.
        repeat (10) @(posedge clkin);
        @(negedge clkin);
        check("pre_freeze_presc", 32'(presc), 32'd10);
        en = 1'b0;
        repeat (40) @(negedge clkin);
        check("freeze_presc",   32'(presc), 32'd10);
        check("freeze_counter", 32'(counter), 32'h5A);
        en = 1'b1;
        wait_tick(n);
        check("unfreeze_latency", 32'(n), 32'd15);
        check("unfreeze_count",   32'(counter), 32'h5B);

`ifdef PRESCALED_COUNTER_SATURATE_EN
        // Saturation at FF: counter holds, tc pulses on every tick.
        do_load(8'hFF, 1'b1);
        for (int i = 0; i < 2; i++) begin
            wait_tick(n);
            check("sat_counter", 32'(counter), 32'hFF);
            check("sat_tc",      32'(tc), 32'd1);
        end
`endif

        @(negedge clkin);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
